// File: rtl/sprite_plotter.sv
// Car sprite renderer: erases the previous sprite, draws it at the new spot and
// streams one pixel per clock to the VGA adapter, clipping at 160x120.
module sprite_plotter #(
  parameter int         SIZE      = 4,
  parameter logic [8:0] BG_COLOUR = 9'h000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req,
  input  logic [7:0] iX,
  input  logic [6:0] iY,
  input  logic [8:0] iColour,
  output logic [7:0] oX,
  output logic [6:0] oY,
  output logic [8:0] oColour,
  output logic       oPlot,
  output logic       busy,
  output logic       done,
  output logic [1:0] o_state
);

  localparam int CW = (SIZE * SIZE > 1) ? $clog2(SIZE * SIZE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW, S_DONE} state_t;

  state_t        r_state;
  logic [7:0]    r_old_x;
  logic [6:0]    r_old_y;
  logic          r_valid;
  logic [7:0]    r_new_x;
  logic [6:0]    r_new_y;
  logic [8:0]    r_new_c;
  logic [CW-1:0] r_cnt;

  logic [CW-1:0] w_dx;
  logic [CW-1:0] w_dy;
  logic [7:0]    w_base_x;
  logic [6:0]    w_base_y;
  logic [8:0]    w_colour;
  logic [8:0]    w_sum_x;
  logic [7:0]    w_sum_y;
  logic          w_on_screen;
  logic          w_last;

  // Handshake: req is taken only in IDLE; busy holds from acceptance through
  // the last pixel, then done pulses alone for one cycle. req while busy is dropped.
  assign w_dx        = r_cnt % CW'(SIZE);
  assign w_dy        = r_cnt / CW'(SIZE);
  assign w_base_x    = (r_state == S_ERASE) ? r_old_x : r_new_x;
  assign w_base_y    = (r_state == S_ERASE) ? r_old_y : r_new_y;
  assign w_colour    = (r_state == S_ERASE) ? BG_COLOUR : r_new_c;
  assign w_sum_x     = {1'b0, w_base_x} + 9'(w_dx);
  assign w_sum_y     = {1'b0, w_base_y} + 8'(w_dy);
  assign w_on_screen = (w_sum_x <= 9'd159) && (w_sum_y <= 8'd119);
  assign w_last      = (r_cnt == CW'(SIZE * SIZE - 1));
  assign o_state     = r_state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_old_x <= '0;
      r_old_y <= '0;
      r_valid <= 1'b0;
      r_new_x <= '0;
      r_new_y <= '0;
      r_new_c <= '0;
      r_cnt   <= '0;
      oX      <= '0;
      oY      <= '0;
      oColour <= '0;
      oPlot   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          oPlot <= 1'b0;
          done  <= 1'b0;
          if (req) begin
            r_new_x <= iX;
            r_new_y <= iY;
            r_new_c <= iColour;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= r_valid ? S_ERASE : S_DRAW;
          end
        end
        S_ERASE, S_DRAW: begin
          // Clipped pixels still take their cycle; only the strobe is masked.
          oX      <= w_sum_x[7:0];
          oY      <= w_sum_y[6:0];
          oColour <= w_colour;
          oPlot   <= w_on_screen;
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= (r_state == S_ERASE) ? S_DRAW : S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          oPlot   <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b1;
          r_old_x <= r_new_x;
          r_old_y <= r_new_y;
          r_valid <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_plotter.sv
// Bench for sprite_plotter: directed and random updates checked against a
// pixel-list model built from the erase/draw/clip rules.
module tb_sprite_plotter;

  localparam int         SIZE = 4;
  localparam logic [8:0] BG   = 9'h000;

  logic       clock;
  logic       reset;
  logic       req;
  logic [7:0] iX;
  logic [6:0] iY;
  logic [8:0] iColour;
  logic [7:0] oX;
  logic [6:0] oY;
  logic [8:0] oColour;
  logic       oPlot;
  logic       busy;
  logic       done;
  logic [1:0] dbg_state;

  sprite_plotter #(.SIZE(SIZE), .BG_COLOUR(BG)) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .iX      (iX),
    .iY      (iY),
    .iColour (iColour),
    .oX      (oX),
    .oY      (oY),
    .oColour (oColour),
    .oPlot   (oPlot),
    .busy    (busy),
    .done    (done),
    .o_state (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int  n_pass  = 0;
  int  n_total = 0;
  int  m_old_x = 0;
  int  m_old_y = 0;
  bit  m_valid = 1'b0;

  // expected pixel stream: {plot, colour[8:0], y[6:0], x[7:0]}
  logic [24:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic void scan(input int bx, input int by, input logic [8:0] c);
    for (int dy = 0; dy < SIZE; dy++) begin
      for (int dx = 0; dx < SIZE; dx++) begin
        int   sx;
        int   sy;
        logic p;
        sx = bx + dx;
        sy = by + dy;
        p  = (sx < 160) && (sy < 120);
        exp_q.push_back({p, c, 7'(sy), 8'(sx)});
      end
    end
  endfunction

  function automatic void plan(input int x, input int y, input logic [8:0] c);
    exp_q.delete();
    if (m_valid) scan(m_old_x, m_old_y, BG);
    scan(x, y, c);
  endfunction

  task automatic check_pix();
    logic [24:0] e;
    e = exp_q.pop_front();
    check("pix_x",      {24'd0, oX},      {24'd0, e[7:0]});
    check("pix_y",      {25'd0, oY},      {25'd0, e[14:8]});
    check("pix_colour", {23'd0, oColour}, {23'd0, e[23:15]});
    check("pix_plot",   {31'd0, oPlot},   {31'd0, e[24]});
    check("pix_busy",   {31'd0, busy},    32'd1);
    check("pix_done",   {31'd0, done},    32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_x"},      {24'd0, oX},      32'd0);
    check({tag, "_y"},      {25'd0, oY},      32'd0);
    check({tag, "_colour"}, {23'd0, oColour}, 32'd0);
    check({tag, "_plot"},   {31'd0, oPlot},   32'd0);
    check({tag, "_busy"},   {31'd0, busy},    32'd0);
    check({tag, "_done"},   {31'd0, done},    32'd0);
  endtask

  // driver: one complete update; chatter re-pulses req and scrambles inputs
  // while busy, hold leaves req high so the next update follows immediately.
  task automatic do_update(input int x, input int y, input logic [8:0] c,
                           input bit chatter, input bit hold);
    int n;
    plan(x, y, c);
    n       = exp_q.size();
    req     = 1'b1;
    iX      = 8'(x);
    iY      = 7'(y);
    iColour = c;
    @(posedge clock); #1;
    if (!hold) req = 1'b0;
    check("accept_busy", {31'd0, busy},  32'd1);
    check("accept_plot", {31'd0, oPlot}, 32'd0);
    check("accept_done", {31'd0, done},  32'd0);
    for (int i = 0; i < n; i++) begin
      if (chatter) begin
        req     = 1'b1;
        iX      = 8'($urandom);
        iY      = 7'($urandom);
        iColour = 9'($urandom);
      end
      @(posedge clock); #1;
      check_pix();
    end
    if (!hold) req = 1'b0;
    @(posedge clock); #1;
    check("done_pulse", {31'd0, done},  32'd1);
    check("done_busy",  {31'd0, busy},  32'd0);
    check("done_plot",  {31'd0, oPlot}, 32'd0);
    m_old_x = x;
    m_old_y = y;
    m_valid = 1'b1;
  endtask

  initial begin
    reset   = 1'b1;
    req     = 1'b0;
    iX      = '0;
    iY      = '0;
    iColour = '0;
    repeat (2) @(posedge clock);
    #1;
    check_zero("reset");
    reset = 1'b0;
    @(posedge clock); #1;
    check_zero("idle");

    // first draw, then one-pixel move
    do_update(10, 20, 9'h1C0, 1'b0, 1'b0);
    do_update(11, 20, 9'h1C0, 1'b0, 1'b0);

    // clipping at the bottom-right corner, then erase of the 4 visible pixels
    reset = 1'b1;
    @(posedge clock); #1;
    reset   = 1'b0;
    m_valid = 1'b0;
    do_update(158, 118, 9'h0F5, 1'b0, 1'b0);
    do_update(0, 0, 9'h03F, 1'b0, 1'b0);

    // req chatter and input changes during an update
    do_update($urandom_range(0, 150), $urandom_range(0, 110), 9'($urandom), 1'b1, 1'b0);

    // random positions, including off-screen and wrap-prone coordinates
    repeat (6) begin
      do_update($urandom_range(0, 255), $urandom_range(0, 127), 9'($urandom), 1'b0, 1'b0);
    end
    do_update(255, 127, 9'h1FF, 1'b0, 1'b0);

    // reset during draw pixel 5
    plan(40, 50, 9'h155);
    req     = 1'b1;
    iX      = 8'd40;
    iY      = 7'd50;
    iColour = 9'h155;
    @(posedge clock); #1;
    req = 1'b0;
    for (int i = 0; i < SIZE * SIZE + 6; i++) begin
      @(posedge clock); #1;
      check_pix();
    end
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    @(posedge clock); #1;
    reset   = 1'b0;
    m_valid = 1'b0;
    check_zero("post_reset");
    do_update(60, 30, 9'h0AA, 1'b0, 1'b0);

    // req held high: back-to-back updates
    do_update(20, 10, 9'h111, 1'b0, 1'b1);
    do_update(21, 11, 9'h122, 1'b0, 1'b1);
    do_update($urandom_range(0, 255), $urandom_range(0, 127), 9'($urandom), 1'b0, 1'b0);

    @(posedge clock); #1;
    check("final_idle_busy", {31'd0, busy}, 32'd0);
    check("final_idle_done", {31'd0, done}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
